// File: rtl/avr_cpu_regpair_seq.sv
// Sequences 16-bit register-pair ops (ADIW/SBIW/MOVW/LD16) onto the 8-bit single-port register file.
// Optional DEBUG_PORT_EN macro adds a debug read/write port served while idle.
`timescale 1ns/1ps
module avr_cpu_regpair_seq #(
    parameter int IMM_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [1:0]       op,
    input  logic [4:0]       d_base,
    input  logic [4:0]       r_base,
    input  logic [IMM_W-1:0] imm,
    input  logic [15:0]      wdata,
    output logic             ack,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output logic [4:0]       flags,
    output logic             flags_we,
    output logic [4:0]       rf_r_addr,
    output logic [4:0]       rf_d_addr,
    input  logic [7:0]       rf_r_out,
    input  logic [7:0]       rf_d_out,
    output logic [7:0]       rf_d_in,
`ifdef DEBUG_PORT_EN
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [4:0]       dbg_addr,
    input  logic [7:0]       dbg_wdata,
    output logic [7:0]       dbg_rdata,
    output logic             dbg_ack,
`endif
    output logic             rf_we
);

    localparam logic [1:0] OP_ADIW = 2'b00;
    localparam logic [1:0] OP_SBIW = 2'b01;
    localparam logic [1:0] OP_MOVW = 2'b10;
    localparam logic [1:0] OP_LD16 = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       op_reg;
    logic [4:1]       d_pair_reg;
    logic [4:1]       r_pair_reg;
    logic [IMM_W-1:0] imm_reg;
    logic [15:0]      wdata_reg;
    logic             carry_reg;
    logic [15:0]      result_reg;
    logic [4:0]       flags_reg;

    logic [15:0] imm_ext;
    logic [8:0]  lo_sum, lo_diff;
    logic [7:0]  hi_sum, hi_diff;
    logic [7:0]  byte_val;
    logic [15:0] r_word;
    logic [4:0]  flags_next;
    logic        is_arith;
    logic        unused_bits;

    // Pair bit0 is ignored by definition; only [4:1] is captured.
    assign unused_bits = d_base[0] ^ r_base[0];

    assign imm_ext  = 16'(imm_reg);
    assign is_arith = (op_reg == OP_ADIW) || (op_reg == OP_SBIW);
    assign lo_sum   = {1'b0, rf_d_out} + {1'b0, imm_ext[7:0]};
    assign lo_diff  = {1'b0, rf_d_out} - {1'b0, imm_ext[7:0]};
    assign hi_sum   = rf_d_out + imm_ext[15:8] + {7'b0, carry_reg};
    assign hi_diff  = rf_d_out - imm_ext[15:8] - {7'b0, carry_reg};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (req) state_next = S_LO;
            S_LO:   state_next = S_HI;
            S_HI:   state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Byte produced in the current half-cycle of the op
    always_comb begin
        byte_val = 8'h00;
        if (state_reg == S_LO) begin
            case (op_reg)
                OP_ADIW: byte_val = lo_sum[7:0];
                OP_SBIW: byte_val = lo_diff[7:0];
                OP_MOVW: byte_val = rf_r_out;
                default: byte_val = wdata_reg[7:0];
            endcase
        end else if (state_reg == S_HI) begin
            case (op_reg)
                OP_ADIW: byte_val = hi_sum;
                OP_SBIW: byte_val = hi_diff;
                OP_MOVW: byte_val = rf_r_out;
                default: byte_val = wdata_reg[15:8];
            endcase
        end
    end

    // Word flags, evaluated in HI while the original high byte is still on rf_d_out
    always_comb begin
        logic n, z, v, c;
        r_word = {byte_val, result_reg[7:0]};
        n = r_word[15];
        z = (r_word == 16'h0000);
        if (op_reg == OP_SBIW) begin
            v = rf_d_out[7] & ~r_word[15];
            c = r_word[15] & ~rf_d_out[7];
        end else begin
            v = ~rf_d_out[7] & r_word[15];
            c = ~r_word[15] & rf_d_out[7];
        end
        flags_next = {n ^ v, v, n, z, c};
    end

`ifdef DEBUG_PORT_EN
    logic       dbg_serve;
    logic [7:0] dbg_rdata_reg;
    logic       dbg_ack_reg;

    // CPU request has priority over a debug access in the same cycle.
    assign dbg_serve = rst && (state_reg == S_IDLE) && !req && dbg_req;
    assign dbg_rdata = dbg_rdata_reg;
    assign dbg_ack   = dbg_ack_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_rdata_reg <= 8'h00;
            dbg_ack_reg   <= 1'b0;
        end else begin
            dbg_ack_reg <= dbg_serve;
            if (dbg_serve) dbg_rdata_reg <= rf_d_out;
        end
    end
`endif

    // Output logic
    always_comb begin
        ack       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        flags_we  = 1'b0;
        rf_we     = 1'b0;
        rf_d_addr = 5'd0;
        rf_r_addr = 5'd0;
        rf_d_in   = 8'h00;
        case (state_reg)
            S_IDLE: begin
                ack = rst & req;
`ifdef DEBUG_PORT_EN
                if (dbg_serve) begin
                    rf_d_addr = dbg_addr;
                    rf_we     = dbg_we;
                    rf_d_in   = dbg_wdata;
                end
`endif
            end
            S_LO: begin
                busy      = 1'b1;
                rf_we     = 1'b1;
                rf_d_addr = {d_pair_reg, 1'b0};
                rf_r_addr = {r_pair_reg, 1'b0};
                rf_d_in   = byte_val;
            end
            S_HI: begin
                busy      = 1'b1;
                rf_we     = 1'b1;
                rf_d_addr = {d_pair_reg, 1'b1};
                rf_r_addr = {r_pair_reg, 1'b1};
                rf_d_in   = byte_val;
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                flags_we = is_arith;
            end
            default: ;
        endcase
    end

    // Captured request, inter-byte carry/borrow and held result/flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg     <= 2'b00;
            d_pair_reg <= 4'd0;
            r_pair_reg <= 4'd0;
            imm_reg    <= '0;
            wdata_reg  <= 16'h0000;
            carry_reg  <= 1'b0;
            result_reg <= 16'h0000;
            flags_reg  <= 5'b00000;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        op_reg     <= op;
                        d_pair_reg <= d_base[4:1];
                        r_pair_reg <= r_base[4:1];
                        imm_reg    <= imm;
                        wdata_reg  <= wdata;
                    end
                end
                S_LO: begin
                    result_reg[7:0] <= byte_val;
                    carry_reg       <= (op_reg == OP_SBIW) ? lo_diff[8] : lo_sum[8];
                end
                S_HI: begin
                    result_reg[15:8] <= byte_val;
                    if (is_arith) flags_reg <= flags_next;
                end
                default: ;
            endcase
        end
    end

    assign result = result_reg;
    assign flags  = flags_reg;

endmodule

// File: tb/tb_avr_cpu_regpair_seq.sv
// Directed bench for avr_cpu_regpair_seq with a behavioural 32x8 register file.
`timescale 1ns/1ps
module tb_avr_cpu_regpair_seq;

    localparam int IMM_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [4:0]       d_base = 5'd0;
    logic [4:0]       r_base = 5'd0;
    logic [IMM_W-1:0] imm = '0;
    logic [15:0]      wdata = 16'h0000;
    logic             ack, busy, done, flags_we, rf_we;
    logic [15:0]      result;
    logic [4:0]       flags;
    logic [4:0]       rf_r_addr, rf_d_addr;
    logic [7:0]       rf_r_out, rf_d_out, rf_d_in;

    logic [7:0] rf_model [32];
    logic       load_en = 1'b0;
    logic [4:0] load_addr = 5'd0;
    logic [7:0] load_data = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avr_cpu_regpair_seq #(.IMM_W(IMM_W)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .d_base(d_base), .r_base(r_base),
        .imm(imm), .wdata(wdata), .ack(ack), .busy(busy), .done(done),
        .result(result), .flags(flags), .flags_we(flags_we),
        .rf_r_addr(rf_r_addr), .rf_d_addr(rf_d_addr), .rf_r_out(rf_r_out),
        .rf_d_out(rf_d_out), .rf_d_in(rf_d_in), .rf_we(rf_we)
    );

    assign rf_r_out = rf_model[rf_r_addr];
    assign rf_d_out = rf_model[rf_d_addr];

    always @(posedge clk) begin
        if (load_en) rf_model[load_addr] <= load_data;
        else if (rf_we) rf_model[rf_d_addr] <= rf_d_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_pair(input logic [4:0] addr, input logic [15:0] val);
        @(negedge clk);
        load_en = 1'b1; load_addr = {addr[4:1], 1'b0}; load_data = val[7:0];
        @(negedge clk);
        load_addr = {addr[4:1], 1'b1}; load_data = val[15:8];
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [4:0] d,
                          input logic [4:0] r, input logic [IMM_W-1:0] im, input logic [15:0] wd,
                          input logic [15:0] exp_res, input logic [4:0] exp_flags, input logic exp_fwe);
        logic [4:0] lo_a, hi_a;
        lo_a = {d[4:1], 1'b0};
        hi_a = {d[4:1], 1'b1};
        @(negedge clk);
        op = o; d_base = d; r_base = r; imm = im; wdata = wd; req = 1'b1;
        #1 check({name, " ack"}, ack, 1'b1);
        @(negedge clk);
        req = 1'b0;
        check({name, " lo busy"}, busy, 1'b1);
        check({name, " lo rf_we"}, rf_we, 1'b1);
        check({name, " lo addr"}, rf_d_addr, lo_a);
        if (o == 2'b10) check({name, " lo r_addr"}, rf_r_addr, {r[4:1], 1'b0});
        @(negedge clk);
        check({name, " hi addr"}, rf_d_addr, hi_a);
        check({name, " lo byte"}, rf_model[lo_a], exp_res[7:0]);
        @(negedge clk);
        check({name, " done"}, done, 1'b1);
        check({name, " rf_we in done"}, rf_we, 1'b0);
        check({name, " hi byte"}, rf_model[hi_a], exp_res[15:8]);
        check({name, " result"}, result, exp_res);
        check({name, " flags_we"}, flags_we, exp_fwe);
        if (exp_fwe) check({name, " flags"}, flags, exp_flags);
        $display("op %s d=%0d r=%0d -> result=0x%04h flags=%05b flags_we=%0b",
                 name, d, r, result, flags, flags_we);
        @(negedge clk);
        check({name, " done pulse"}, done, 1'b0);
    endtask

    initial begin
        int acks;
        // Reset state with req asserted
        req = 1'b1;
        repeat (2) @(negedge clk);
        check("rst ack", ack, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst rf_we", rf_we, 1'b0);
        check("rst result", result, 16'h0000);
        check("rst flags", flags, 5'b00000);
        check("rst rf_d_addr", rf_d_addr, 5'd0);
        req = 1'b0;
        rst = 1'b1;

        load_pair(5'd24, 16'h00FF);
        run_op("ADIW_0x00FF+1", 2'b00, 5'd24, 5'd0, 6'd1, 16'h0, 16'h0100, 5'b00000, 1'b1);
        load_pair(5'd26, 16'hFFFF);
        run_op("ADIW_wrap", 2'b00, 5'd27, 5'd0, 6'd1, 16'h0, 16'h0000, 5'b00011, 1'b1);
        load_pair(5'd28, 16'h8000);
        run_op("SBIW_0x8000-1", 2'b01, 5'd28, 5'd0, 6'd1, 16'h0, 16'h7FFF, 5'b11000, 1'b1);
        load_pair(5'd20, 16'h0000);
        run_op("SBIW_wrap", 2'b01, 5'd20, 5'd0, 6'd1, 16'h0, 16'hFFFF, 5'b10101, 1'b1);
        load_pair(5'd22, 16'h7FC1);
        run_op("ADIW_imm63", 2'b00, 5'd22, 5'd0, 6'd63, 16'h0, 16'h8000, 5'b01100, 1'b1);
        load_pair(5'd30, 16'h1234);
        run_op("MOVW_r30", 2'b10, 5'd2, 5'd30, 6'd0, 16'h0, 16'h1234, 5'b00000, 1'b0);
        load_pair(5'd8, 16'hA55A);
        run_op("MOVW_self", 2'b10, 5'd8, 5'd8, 6'd0, 16'h0, 16'hA55A, 5'b00000, 1'b0);
        run_op("LD16", 2'b11, 5'd10, 5'd0, 6'd0, 16'hCAFE, 16'hCAFE, 5'b00000, 1'b0);

        // req held high across two back-to-back ops
        @(negedge clk);
        op = 2'b10; d_base = 5'd4; r_base = 5'd30; req = 1'b1;
        acks = 0;
        for (int k = 0; k < 9; k++) begin
            #1;
            if (ack) acks++;
            if (k == 3 || k == 7) check($sformatf("held done k=%0d", k), done, 1'b1);
            if (k == 4) check("held second ack", ack, 1'b1);
            if (k == 7) req = 1'b0;
            @(negedge clk);
        end
        check("held ack count", acks, 2);
        check("held r4", rf_model[4], 8'h34);
        check("held r5", rf_model[5], 8'h12);
        $display("op MOVW_held d=4 r=30 acks=%0d", acks);

        // Reset asserted during HI of an LD16
        load_pair(5'd16, 16'h2211);
        @(negedge clk);
        op = 2'b11; d_base = 5'd16; wdata = 16'hBEEF; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0; req = 1'b1;
        #1;
        check("midrst busy", busy, 1'b0);
        check("midrst rf_we", rf_we, 1'b0);
        check("midrst ack", ack, 1'b0);
        check("midrst result", result, 16'h0000);
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        check("midrst lo byte", rf_model[16], 8'hEF);
        check("midrst hi byte", rf_model[17], 8'h22);
        $display("op LD16_reset d=16 -> r16=0x%02h r17=0x%02h", rf_model[16], rf_model[17]);
        run_op("ADIW_after_rst", 2'b00, 5'd16, 5'd0, 6'd1, 16'h0, 16'h22F0, 5'b00000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avr_cpu_regpair_seq.md
Name: avr_cpu_regpair_seq

Overview:
Sequences 16-bit register-pair operations (ADIW, SBIW, MOVW, 16-bit pointer write-back) onto the 8-bit, single-write-port CPU register file.
- Each word op is split into a low-byte cycle and a high-byte cycle, with carry/borrow propagated between them.
- AVR word-op flags are produced on completion.
- Sits between the CPU decode/execute stage and the register file, and owns the register-file address and write lines while busy.

Parameters:
- IMM_W, 6, width of the ADIW/SBIW immediate (zero-extended to 16 bits).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  CPU requests a word op; sampled only in IDLE.
- op  in  2  00 ADIW, 01 SBIW, 10 MOVW, 11 LD16 (write wdata to pair).
- d_base  in  5  destination pair address; bit0 ignored.
- r_base  in  5  source pair address for MOVW; bit0 ignored.
- imm  in  IMM_W  immediate for ADIW/SBIW.
- wdata  in  16  word for LD16.
- ack  out  1  one-cycle pulse: request accepted.
- busy  out  1  high in LO, HI, DONE.
- done  out  1  one-cycle pulse: op complete, result/flags valid.
- result  out  16  final pair value; held until next done.
- flags  out  5  {S,V,N,Z,C}; valid with done.
- flags_we  out  1  pulses with done for ADIW/SBIW only.
- rf_r_addr  out  5  register-file read address r.
- rf_d_addr  out  5  register-file read/write address d.
- rf_r_out  in  8  register-file read data r (combinational).
- rf_d_out  in  8  register-file read data d (combinational).
- rf_d_in  out  8  write data.
- rf_we  out  1  write enable for rf_d_addr.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - ack, busy, done, flags_we and rf_we are 0.
  - result, flags and the captured inputs are 0.
  - rf addresses are 0.
- FSM states: IDLE -> LO -> HI -> DONE -> IDLE. Each state lasts one cycle.
- IDLE:
  - If req=1: pulse ack, capture op, d_base, r_base, imm, wdata, then go to LO.
  - req is ignored in every other state; the requester must re-present it after done.
- LO:
  - rf_d_addr = {d_base[4:1],0}; rf_r_addr = {r_base[4:1],0}; rf_we=1.
  - ADIW: lo = d_out + imm, carry saved.
  - SBIW: lo = d_out - imm, borrow saved.
  - MOVW: lo = r_out.
  - LD16: lo = wdata[7:0].
  - lo is written and also stored in result[7:0].
- HI:
  - Addresses use bit0 = 1; rf_we=1.
  - ADIW: hi = d_out + carry.
  - SBIW: hi = d_out - borrow.
  - MOVW: hi = r_out.
  - LD16: hi = wdata[15:8].
  - The original d_out[7] is saved as Rdh7.
- DONE:
  - rf_we=0; done=1; result is valid.
  - flags_we=1 for ADIW/SBIW, 0 otherwise.
- Flags (R = 16-bit result):
  - N = R[15].
  - Z = (R==0).
  - ADIW: V = !Rdh7 & R15; C = !R15 & Rdh7.
  - SBIW: V = Rdh7 & !R15; C = R15 & !Rdh7.
  - S = N ^ V.
  - All arithmetic is modulo 2^16; wrap-around is legal.
- Outside LO/HI, rf_we=0 and the rf addresses are don't-care (driven to 0).
- Overall latency: req accepted on edge 0; low byte written on edge 1; high byte on edge 2; done high during cycle 3.
- Reset during HI: the low byte may already be committed; the high byte is not written. This is accepted behaviour.
- MOVW with d_base == r_base is legal: same value written back, no hazard.

Optional Feature:
DEBUG_PORT_EN
- Adds ports dbg_req (in, 1), dbg_we (in, 1), dbg_addr (in, 5), dbg_wdata (in, 8), dbg_rdata (out, 8), dbg_ack (out, 1).
- A debug access is served only in IDLE with req=0; CPU req wins when both arrive in the same cycle.
- Serving a debug access:
  - rf_d_addr = dbg_addr.
  - rf_we = dbg_we, rf_d_in = dbg_wdata.
  - dbg_rdata is registered from rf_d_out.
  - dbg_ack pulses on the next cycle.
- dbg_rdata resets to 0.
- Without the macro: the ports are absent and the debug logic is not synthesised; behaviour is exactly as above.

Test Plan:
- ADIW d_base=24, r24=0xFF, r25=0x00, imm=1 -> r24←0x00 on edge 1, r25←0x01 on edge 2, done in cycle 3, result 0x0100, flags S,V,N,Z,C = 0,0,0,0,0.
- ADIW pair=0xFFFF, imm=1 -> result 0x0000, Z=1, C=1, V=0, N=0.
- SBIW pair=0x8000, imm=1 -> result 0x7FFF, V=1, N=0, S=1, C=0, Z=0.
- MOVW d_base=2, r_base=30, r30=0x34, r31=0x12 -> r2=0x34, r3=0x12, flags_we=0, done after 3 cycles.
- req held high through busy -> exactly one ack per op; second op's ack appears in the IDLE cycle after done.
- LD16 wdata=0xBEEF with rst=0 asserted during HI -> low byte 0xEF written, high byte unchanged, all outputs 0 immediately, next req is accepted normally.
